por_sw_conditioner: RTL and testbench

POR_SW_CONDITIONER -- requirements
Module: por_sw_conditioner

---
 rtl/por_sw_conditioner_if.sv | 21 ++
 rtl/por_sw_conditioner.sv | 131 +++++++++++++
 tb/tb_por_sw_conditioner.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/por_sw_conditioner_if.sv
// rtl/por_sw_conditioner_if.sv - reset request, raw switch inputs and conditioned outputs
interface por_sw_conditioner_if #(
    parameter int NumSw = 13
);
    logic             rst_req_i;
    logic [NumSw-1:0] sw_raw_i;
    logic             rst_n_o;
    logic [NumSw-1:0] sw_o;
    logic [NumSw-1:0] sw_rise_o;
    logic [NumSw-1:0] sw_fall_o;

    modport master (
        output rst_req_i, sw_raw_i,
        input  rst_n_o, sw_o, sw_rise_o, sw_fall_o
    );

    modport slave (
        input  rst_req_i, sw_raw_i,
        output rst_n_o, sw_o, sw_rise_o, sw_fall_o
    );
endinterface

// File: rtl/por_sw_conditioner.sv
// rtl/por_sw_conditioner.sv - power-on reset pulse sequencer plus per-channel switch debouncer
module por_sw_conditioner #(
    parameter int               NumSw          = 13,
    parameter logic [NumSw-1:0] ActiveLowSw    = {NumSw{1'b1}},
    parameter int               PreCycles      = 5,
    parameter int               HoldCycles     = 195,
    parameter int               DebounceCycles = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    por_sw_conditioner_if.slave   bus
);
    localparam int SeqMax = (PreCycles > HoldCycles) ? PreCycles : HoldCycles;
    localparam int SeqW   = $clog2(SeqMax + 1);
    localparam int DbW    = $clog2(DebounceCycles + 1);

    localparam logic [SeqW-1:0] PreLast  = SeqW'((PreCycles == 0) ? 0 : PreCycles - 1);
    localparam logic [SeqW-1:0] HoldLast = SeqW'(HoldCycles - 1);
    localparam logic [DbW-1:0]  DbLast   = DbW'(DebounceCycles - 1);

    typedef enum logic [1:0] {
        ST_PRE,
        ST_HOLD,
        ST_RUN
    } seq_state_e;

    seq_state_e      state_q, state_d;
    logic [SeqW-1:0] seq_cnt_q, seq_cnt_d;
    logic            rst_n_q, rst_n_d;

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        case (state_q)
            ST_PRE: begin
                if (PreCycles == 0 || seq_cnt_q == PreLast) begin
                    state_d   = ST_HOLD;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SeqW'(1);
                end
            end
            ST_HOLD: begin
                // A request during hold restarts the full hold window.
                if (bus.rst_req_i) begin
                    seq_cnt_d = '0;
                end else if (seq_cnt_q == HoldLast) begin
                    state_d   = ST_RUN;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SeqW'(1);
                end
            end
            ST_RUN: begin
                if (bus.rst_req_i) begin
                    state_d   = ST_HOLD;
                    seq_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_PRE;
                seq_cnt_d = '0;
            end
        endcase
        rst_n_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_PRE;
            seq_cnt_q <= '0;
            rst_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            rst_n_q   <= rst_n_d;
        end
    end

    logic [NumSw-1:0] sync1_q, sync2_q;
    logic [NumSw-1:0] sw_norm;
    logic [NumSw-1:0] sw_q, sw_d;
    logic [NumSw-1:0] rise_q, rise_d;
    logic [NumSw-1:0] fall_q, fall_d;
    logic [DbW-1:0]   db_cnt_q [NumSw];
    logic [DbW-1:0]   db_cnt_d [NumSw];

    assign sw_norm = sync2_q ^ ActiveLowSw;

    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < NumSw; i++) begin
            db_cnt_d[i] = '0;
            if (sw_norm[i] != sw_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    sw_d[i]   = sw_norm[i];
                    rise_d[i] = sw_norm[i];
                    fall_d[i] = ~sw_norm[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Synchronisers reset to the polarity-normalised "off" level so reset never looks like a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= ActiveLowSw;
            sync2_q  <= ActiveLowSw;
            sw_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            db_cnt_q <= '{default: '0};
        end else begin
            sync1_q  <= bus.sw_raw_i;
            sync2_q  <= sync1_q;
            sw_q     <= sw_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign bus.rst_n_o   = rst_n_q;
    assign bus.sw_o      = sw_q;
    assign bus.sw_rise_o = rise_q;
    assign bus.sw_fall_o = fall_q;
endmodule

// File: tb/tb_por_sw_conditioner.sv
// tb/tb_por_sw_conditioner.sv - directed-vector bench for por_sw_conditioner
module tb_por_sw_conditioner;
    localparam int             NumSw          = 4;
    localparam logic [NumSw-1:0] ActiveLowSw  = 4'b1111;
    localparam int             PreCycles      = 5;
    localparam int             HoldCycles     = 195;
    localparam int             DebounceCycles = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    por_sw_conditioner_if #(.NumSw(NumSw)) bus ();

    por_sw_conditioner #(
        .NumSw          (NumSw),
        .ActiveLowSw    (ActiveLowSw),
        .PreCycles      (PreCycles),
        .HoldCycles     (HoldCycles),
        .DebounceCycles (DebounceCycles)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_rst_n;
        rst = 1'b1;
        bus.rst_req_i = 1'b0;
        bus.sw_raw_i = 4'hF;
        step();
        step();
        vectors++;
        if (bus.rst_n_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rst_n: got %b expected 1", bus.rst_n_o);
        end
        vectors++;
        if (bus.sw_o !== 4'h0 || bus.sw_rise_o !== 4'h0 || bus.sw_fall_o !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_sw: got sw=%h rise=%h fall=%h expected 0/0/0",
                     bus.sw_o, bus.sw_rise_o, bus.sw_fall_o);
        end
        rst = 1'b0;
        for (int k = 0; k < 210; k++) begin
            exp_rst_n = !(k >= 5 && k <= 199);
            vectors++;
            if (bus.rst_n_o !== exp_rst_n) begin
                miscompares++;
                $display("FAIL por_seq cycle %0d: got %b expected %b", k, bus.rst_n_o, exp_rst_n);
            end
            step();
        end
    endtask

    task automatic test_rst_req();
        logic exp_rst_n;
        vectors++;
        if (bus.rst_n_o !== 1'b1) begin
            miscompares++;
            $display("FAIL req_pre_run: got %b expected 1", bus.rst_n_o);
        end
        bus.rst_req_i = 1'b1;
        step();
        bus.rst_req_i = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            exp_rst_n = (i > 295);
            vectors++;
            if (bus.rst_n_o !== exp_rst_n) begin
                miscompares++;
                $display("FAIL req_hold cycle +%0d: got %b expected %b", i, bus.rst_n_o, exp_rst_n);
            end
            bus.rst_req_i = (i == 100);
            step();
        end
        bus.rst_req_i = 1'b0;
    endtask

    task automatic test_single_press();
        logic [3:0] exp_sw, exp_rise, exp_fall;
        bus.sw_raw_i = 4'hE;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_sw   = (e >= 6) ? 4'h1 : 4'h0;
            exp_rise = (e == 6) ? 4'h1 : 4'h0;
            vectors++;
            if (bus.sw_o !== exp_sw || bus.sw_rise_o !== exp_rise || bus.sw_fall_o !== 4'h0) begin
                miscompares++;
                $display("FAIL press edge %0d: got sw=%h rise=%h fall=%h expected %h/%h/0",
                         e, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o, exp_sw, exp_rise);
            end
        end
        bus.sw_raw_i = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_sw   = (e >= 6) ? 4'h0 : 4'h1;
            exp_fall = (e == 6) ? 4'h1 : 4'h0;
            vectors++;
            if (bus.sw_o !== exp_sw || bus.sw_fall_o !== exp_fall || bus.sw_rise_o !== 4'h0) begin
                miscompares++;
                $display("FAIL release edge %0d: got sw=%h rise=%h fall=%h expected %h/0/%h",
                         e, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o, exp_sw, exp_fall);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_sw, exp_rise, exp_fall;
        for (int k = 0; k < 12; k++) begin
            bus.sw_raw_i = (k == 3) ? 4'hF : 4'hD;
            step();
            exp_sw   = (k + 1 >= 10) ? 4'h2 : 4'h0;
            exp_rise = (k + 1 == 10) ? 4'h2 : 4'h0;
            vectors++;
            if (bus.sw_o !== exp_sw || bus.sw_rise_o !== exp_rise || bus.sw_fall_o !== 4'h0) begin
                miscompares++;
                $display("FAIL bounce edge %0d: got sw=%h rise=%h fall=%h expected %h/%h/0",
                         k + 1, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o, exp_sw, exp_rise);
            end
        end
        bus.sw_raw_i = 4'hF;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp_sw   = (e >= 6) ? 4'h0 : 4'h2;
            exp_fall = (e == 6) ? 4'h2 : 4'h0;
            vectors++;
            if (bus.sw_o !== exp_sw || bus.sw_fall_o !== exp_fall || bus.sw_rise_o !== 4'h0) begin
                miscompares++;
                $display("FAIL bounce_release edge %0d: got sw=%h rise=%h fall=%h expected %h/0/%h",
                         e, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o, exp_sw, exp_fall);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_sw, exp_rise, exp_fall;
        for (int k = 0; k < 20; k++) begin
            bus.sw_raw_i = (k < 10) ? 4'h0 : 4'hF;
            step();
            exp_sw   = (k + 1 >= 6 && k + 1 < 16) ? 4'hF : 4'h0;
            exp_rise = (k + 1 == 6)  ? 4'hF : 4'h0;
            exp_fall = (k + 1 == 16) ? 4'hF : 4'h0;
            vectors++;
            if (bus.sw_o !== exp_sw || bus.sw_rise_o !== exp_rise || bus.sw_fall_o !== exp_fall) begin
                miscompares++;
                $display("FAIL simul edge %0d: got sw=%h rise=%h fall=%h expected %h/%h/%h",
                         k + 1, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o, exp_sw, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic exp_rst_n;
        bus.sw_raw_i = 4'hC;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 50; k++) step();
        vectors++;
        if (bus.rst_n_o !== 1'b0 || bus.sw_o !== 4'h3) begin
            miscompares++;
            $display("FAIL midhold_pre: got rst_n=%b sw=%h expected 0/3", bus.rst_n_o, bus.sw_o);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (bus.rst_n_o !== 1'b1 || bus.sw_o !== 4'h0 || bus.sw_fall_o !== 4'h0 ||
            bus.sw_rise_o !== 4'h0) begin
            miscompares++;
            $display("FAIL midhold_reset: got rst_n=%b sw=%h rise=%h fall=%h expected 1/0/0/0",
                     bus.rst_n_o, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_rst_n = (k < 5);
            vectors++;
            if (bus.rst_n_o !== exp_rst_n || bus.sw_fall_o !== 4'h0) begin
                miscompares++;
                $display("FAIL restart cycle %0d: got rst_n=%b fall=%h expected %b/0",
                         k, bus.rst_n_o, bus.sw_fall_o, exp_rst_n);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_rst_req();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
